// File: rtl/const_fetch_seq.sv
// const_fetch_seq: fetches a 16-bit constant as two bytes from 8-bit program
// memory and writes it into the constant register with two enable pulses.
//
// Parameters:
//   ADDR_W   - memory address width
//   HI_FIRST - 0: byte at base_addr is the low byte; 1: it is the high byte
//   TIMEOUT  - wait-cycle limit per byte (only used with the macro below)
//
// Optional feature: define CONST_FETCH_TIMEOUT_EN to abort a fetch with an
// err pulse when memory does not answer within TIMEOUT wait cycles. Without
// it the wait states wait indefinitely and err is constant 0.
//
// Ports:
//   clk, reset            - rising-edge clock, async active-high reset
//   start, base_addr      - fetch request (sampled in IDLE only) and address
//   mem_rd, mem_addr      - one-cycle read request per byte
//   mem_rdata, mem_valid  - read response
//   k_data, k_byte_sel,
//   k_ena                 - constant register write port
//   busy, done, err       - status to the control unit
// All outputs are registered.

module const_fetch_seq #(
  parameter int ADDR_W   = 16,
  parameter bit HI_FIRST = 1'b0,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_valid,
  output logic [7:0]        k_data,
  output logic              k_byte_sel,
  output logic              k_ena,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_WT0,
    S_RD1,
    S_WT1,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_rd;
  logic [7:0]          r_k_data;
  logic                r_k_byte_sel;
  logic                r_k_ena;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

`ifdef CONST_FETCH_TIMEOUT_EN
  // Counter is at least 4 bits wide, wider if TIMEOUT needs it.
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  logic [CNT_W-1:0]    r_wcnt;
  logic                w_tmo;

  // The count would reach TIMEOUT at the end of this wait cycle, so leave
  // now. mem_valid is tested first in the FSM, so a late answer still wins.
  assign w_tmo = (r_wcnt == CNT_W'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_mem_addr   <= '0;
      r_mem_rd     <= 1'b0;
      r_k_data     <= 8'h00;
      r_k_byte_sel <= 1'b0;
      r_k_ena      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
`ifdef CONST_FETCH_TIMEOUT_EN
      r_wcnt       <= '0;
`endif
    end else begin
      // Pulse outputs default low; k_data/k_byte_sel hold between pulses.
      r_mem_rd <= 1'b0;
      r_k_ena  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr     <= base_addr;
            r_mem_addr <= base_addr;
            r_mem_rd   <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_RD0;
          end
        end

        S_RD0: begin
          r_state <= S_WT0;
`ifdef CONST_FETCH_TIMEOUT_EN
          r_wcnt  <= '0;
`endif
        end

        S_WT0: begin
          if (mem_valid) begin
            r_k_data     <= mem_rdata;
            r_k_byte_sel <= HI_FIRST;
            r_k_ena      <= 1'b1;
            // Second request issued directly so it lines up with the first k_ena.
            r_mem_rd     <= 1'b1;
            r_mem_addr   <= r_addr + ADDR_W'(1);
            r_state      <= S_RD1;
          end
`ifdef CONST_FETCH_TIMEOUT_EN
          else if (w_tmo) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_wcnt <= r_wcnt + CNT_W'(1);
          end
`endif
        end

        S_RD1: begin
          r_state <= S_WT1;
`ifdef CONST_FETCH_TIMEOUT_EN
          r_wcnt  <= '0;
`endif
        end

        S_WT1: begin
          if (mem_valid) begin
            r_k_data     <= mem_rdata;
            r_k_byte_sel <= ~HI_FIRST;
            r_k_ena      <= 1'b1;
            r_done       <= 1'b1;
            r_state      <= S_DONE;
          end
`ifdef CONST_FETCH_TIMEOUT_EN
          else if (w_tmo) begin
            // The first byte stays written; the control unit treats err as fatal.
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_wcnt <= r_wcnt + CNT_W'(1);
          end
`endif
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rd     = r_mem_rd;
  assign mem_addr   = r_mem_addr;
  assign k_data     = r_k_data;
  assign k_byte_sel = r_k_byte_sel;
  assign k_ena      = r_k_ena;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule
